// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and default widths for the PC / fetch-sequencing block.
package pc_pkg;

  localparam int unsigned PC_W             = 12;
  localparam int unsigned RET_W            = 16;
  localparam int unsigned START_PC_DEFAULT = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_e;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC: hold on stall, relative branch, or sequential step.
// All adds are D-bit with the carry dropped, so wrap is silent both ways.
module pc_next_calc #(
  parameter int unsigned D = 12
) (
  input  logic [D-1:0] pc,
  input  logic [D-1:0] target,
  input  logic         branch_en,
  input  logic         stall,
  output logic [D-1:0] pc_next
);

  always_comb begin
    pc_next = pc;
    if (!stall) begin
      // target is a two's-complement offset added as a raw bit pattern
      if (branch_en) pc_next = pc + target;
      else           pc_next = pc + D'(1);
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter, start/done handshake FSM and saturating retired counter.
module pc_fetch_ctrl
  import pc_pkg::*;
#(
  parameter int unsigned D        = PC_W,
  parameter int unsigned CW       = RET_W,
  parameter logic [D-1:0] START_PC = D'(START_PC_DEFAULT)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          start,
  input  logic          stall,
  input  logic          branch_en,
  input  logic [D-1:0]  target,
  input  logic          halt_req,
  output logic [D-1:0]  prog_ctr,
  output logic          running,
  output logic          done,
  output logic [CW-1:0] retired
);

  state_e         state_q;
  logic [D-1:0]   pc_q;
  logic [D-1:0]   pc_next;
  logic [CW-1:0]  ret_q;
  logic [CW-1:0]  ret_inc;
  logic           running_q;
  logic           done_q;

  pc_next_calc #(
    .D (D)
  ) u_next (
    .pc        (pc_q),
    .target    (target),
    .branch_en (branch_en),
    .stall     (stall),
    .pc_next   (pc_next)
  );

  // Counter sticks at all ones rather than wrapping
  assign ret_inc = (ret_q == {CW{1'b1}}) ? ret_q : ret_q + CW'(1);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      pc_q      <= START_PC;
      ret_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          pc_q  <= START_PC;
          ret_q <= '0;
          if (!start) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end
        end
        RUN: begin
          if (start) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
            pc_q      <= START_PC;
            ret_q     <= '0;
          end else if (halt_req) begin
            // halt outranks stall; the terminator itself counts as retired
            state_q   <= HALTED;
            running_q <= 1'b0;
            done_q    <= 1'b1;
            ret_q     <= ret_inc;
          end else if (!stall) begin
            pc_q  <= pc_next;
            ret_q <= ret_inc;
          end
        end
        HALTED: begin
          if (start) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            pc_q    <= START_PC;
            ret_q   <= '0;
          end
        end
        default: begin
          state_q   <= IDLE;
          running_q <= 1'b0;
          done_q    <= 1'b0;
          pc_q      <= START_PC;
          ret_q     <= '0;
        end
      endcase
    end
  end

  assign prog_ctr = pc_q;
  assign running  = running_q;
  assign done     = done_q;
  assign retired  = ret_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios with literal expectations, then
// random stimulus checked every cycle against a behavioural model.
module tb_pc_fetch_ctrl;

  localparam int PC_MOD  = 4096;
  localparam int RET_MAX = 65535;
  localparam int R4_MAX  = 15;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_HALT  = 2;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        branch_en = 1'b0;
  logic [11:0] target = '0;
  logic        halt_req = 1'b0;

  logic [11:0] prog_ctr, prog_ctr4;
  logic        running, running4, done, done4;
  logic [15:0] retired;
  logic [3:0]  retired4;

  int checks = 0;
  int errors = 0;

  int mode = M_IDLE;
  int m_pc = 0;
  int m_ret = 0;
  int m_ret4 = 0;
  bit m_valid = 1'b0;

  always #5 Clk = ~Clk;

  pc_fetch_ctrl #(.D(12), .CW(16), .START_PC(12'h000)) u_dut (
    .Clk (Clk), .Reset (Reset), .start (start), .stall (stall),
    .branch_en (branch_en), .target (target), .halt_req (halt_req),
    .prog_ctr (prog_ctr), .running (running), .done (done), .retired (retired)
  );

  pc_fetch_ctrl #(.D(12), .CW(4), .START_PC(12'h000)) u_dut4 (
    .Clk (Clk), .Reset (Reset), .start (start), .stall (stall),
    .branch_en (branch_en), .target (target), .halt_req (halt_req),
    .prog_ctr (prog_ctr4), .running (running4), .done (done4), .retired (retired4)
  );

  function automatic int sat1(input int v, input int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: program-level rules, updated at each rising edge
  always @(posedge Clk) begin
    if (Reset) begin
      mode <= M_IDLE; m_pc <= 0; m_ret <= 0; m_ret4 <= 0; m_valid <= 1'b1;
    end else if (mode == M_IDLE) begin
      m_pc <= 0; m_ret <= 0; m_ret4 <= 0;
      if (!start) mode <= M_RUN;
    end else if (mode == M_RUN) begin
      if (start) begin
        mode <= M_IDLE; m_pc <= 0; m_ret <= 0; m_ret4 <= 0;
      end else if (halt_req) begin
        mode <= M_HALT; m_ret <= sat1(m_ret, RET_MAX); m_ret4 <= sat1(m_ret4, R4_MAX);
      end else if (!stall) begin
        m_pc   <= branch_en ? (m_pc + int'(target)) % PC_MOD : (m_pc + 1) % PC_MOD;
        m_ret  <= sat1(m_ret, RET_MAX);
        m_ret4 <= sat1(m_ret4, R4_MAX);
      end
    end else begin
      if (start) begin
        mode <= M_IDLE; m_pc <= 0; m_ret <= 0; m_ret4 <= 0;
      end
    end
  end

  always @(negedge Clk) begin
    if (m_valid) begin
      check("model_pc",       prog_ctr,  m_pc);
      check("model_ret",      retired,   m_ret);
      check("model_running",  running,   (mode == M_RUN));
      check("model_done",     done,      (mode == M_HALT));
      check("model_pc4",      prog_ctr4, m_pc);
      check("model_ret4",     retired4,  m_ret4);
      check("model_running4", running4,  (mode == M_RUN));
      check("model_done4",    done4,     (mode == M_HALT));
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic expect_out(input string name, input int pc, input int ret,
                            input bit run, input bit dn);
    check({name, "_pc"},  prog_ctr, pc);
    check({name, "_ret"}, retired,  ret);
    check({name, "_run"}, running,  run);
    check({name, "_done"}, done,    dn);
  endtask

  initial begin
    step(); step();
    expect_out("reset", 0, 0, 0, 0);

    Reset = 1'b0; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out("idle_hold", 0, 0, 0, 0);
    end
    start = 1'b0;
    step();
    expect_out("run_entry", 0, 0, 1, 0);
    for (int i = 1; i <= 4; i++) begin
      step();
      expect_out("seq_step", i, i, 1, 0);
    end

    branch_en = 1'b1; target = 12'hFFB;
    step(); expect_out("br_back_wrap", 12'hFFF, 5, 1, 0);
    target = 12'h014;
    step(); expect_out("br_fwd_wrap", 12'h013, 6, 1, 0);
    target = 12'hFFF;
    step(); expect_out("br_minus1", 12'h012, 7, 1, 0);
    target = 12'hFF5;
    step(); expect_out("br_to7", 7, 8, 1, 0);

    stall = 1'b1; target = 12'h005;
    step(); expect_out("stall1", 7, 8, 1, 0);
    step(); expect_out("stall2", 7, 8, 1, 0);
    stall = 1'b0; target = 12'h000;
    step(); expect_out("self_loop", 7, 9, 1, 0);
    target = 12'h009;
    step(); expect_out("br_to10", 12'h010, 10, 1, 0);

    branch_en = 1'b0; halt_req = 1'b1;
    step(); expect_out("halt", 12'h010, 11, 0, 1);
    halt_req = 1'b0; branch_en = 1'b1; stall = 1'b1; target = 12'h003;
    step(); expect_out("halt_ign1", 12'h010, 11, 0, 1);
    stall = 1'b0; halt_req = 1'b1;
    step(); expect_out("halt_ign2", 12'h010, 11, 0, 1);
    halt_req = 1'b0; branch_en = 1'b0; start = 1'b1;
    step(); expect_out("halt_start", 0, 0, 0, 0);
    start = 1'b0;
    step(); expect_out("rerun", 0, 0, 1, 0);
    step(); expect_out("rerun_step", 1, 1, 1, 0);

    start = 1'b1; halt_req = 1'b1;
    step(); expect_out("start_beats_halt", 0, 0, 0, 0);
    start = 1'b0; halt_req = 1'b0;
    step(); expect_out("run_again", 0, 0, 1, 0);
    branch_en = 1'b1; target = 12'h055;
    step(); expect_out("br_to55", 12'h055, 1, 1, 0);
    Reset = 1'b1;
    step(); expect_out("mid_reset", 0, 0, 0, 0);

    Reset = 1'b0; branch_en = 1'b0;
    step();
    for (int i = 0; i < 20; i++) step();
    expect_out("long_run", 20, 20, 1, 0);
    check("sat_ret4", retired4, 15);

    // Random phase: inputs change once per cycle, model checks every cycle
    for (int i = 0; i < 3000; i++) begin
      Reset     = ($urandom_range(0, 99) == 0);
      start     = ($urandom_range(0, 24) == 0);
      halt_req  = ($urandom_range(0, 39) == 0);
      stall     = ($urandom_range(0, 3) == 0);
      branch_en = ($urandom_range(0, 2) == 0);
      target    = ($urandom_range(0, 7) == 0) ? 12'h000 : 12'($urandom_range(0, 4095));
      step();
    end

    Reset = 1'b0; start = 1'b0; halt_req = 1'b0; stall = 1'b0; branch_en = 1'b0;
    step(); step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Program-counter and fetch-sequencing block that sits directly downstream of the branch-target lookup table and drives the instruction-memory address. Each cycle it holds, increments, or applies a signed relative offset from the lookup table to the PC. It also runs the start/done program handshake with the testbench host and keeps a saturating count of retired instructions.

## Interface

Parameters:

- D, 12, PC and offset width in bits.
- CW, 16, retired-instruction counter width.
- START_PC, 0, PC value loaded on reset and while start is held.

Ports:

- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- start  in  1  host request. While high, the block is held in IDLE with PC = START_PC; the program begins the cycle after start falls.
- stall  in  1  hold PC and counter this cycle (RUN only).
- branch_en  in  1  taken relative branch this cycle.
- target  in  D  signed two's-complement offset from the branch-target lookup table.
- halt_req  in  1  current instruction is the program terminator.
- prog_ctr  out  D  current PC, registered.
- running  out  1  high in RUN.
- done  out  1  high in HALTED.
- retired  out  CW  count of instructions retired since the last start; saturates at all ones.

## Operation

States are IDLE, RUN and HALTED.

- IDLE:
  - prog_ctr = START_PC, retired = 0, running = 0, done = 0.
  - Leave to RUN on the first cycle where start is low.
- RUN:
  - Per cycle, priority order: start high → IDLE (PC reloads START_PC, retired clears). Then halt_req → HALTED (PC holds, retired +1). Then stall → hold everything. Then branch_en → PC = (PC + target) mod 2^D, retired +1. Otherwise PC = (PC + 1) mod 2^D, retired +1.
- HALTED:
  - PC and retired hold; done = 1.
  - start high → IDLE. halt_req, stall and branch_en are ignored.

Arithmetic rules:

- D-bit unsigned add with the carry discarded; target is added as a raw bit pattern.
- Example: 1111_1111_1111 (-1) means go back one.
- Wrap-around in both directions is legal and silent: PC = 0xFFF + 1 → 0x000; PC = 0x002 + (-5) → 0xFFD.
- target = 0 with branch_en high holds the PC but counts as retired. This is the intentional self-loop.
- retired saturates at 2^CW - 1 and does not wrap.

Other behaviour:

- halt_req is accepted even when stall is high, because halt has priority over stall.
- Reset in any state forces IDLE on the next edge, regardless of the other inputs.

## Timing

- Reset values: prog_ctr = START_PC, retired = 0, running = 0, done = 0, state = IDLE.
- All outputs are registered; there is no combinational input-to-output path.
- PC latency is 1 cycle: inputs sampled at edge N are reflected on prog_ctr after edge N.
- The first instruction address in RUN is START_PC. The first PC change occurs at the edge after the first RUN cycle.
- start falls at edge N: the state becomes RUN after edge N+1. running rises with the state.
- halt_req in RUN at edge N: done = 1 and running = 0 after edge N. done stays high until start or Reset.
- start pulses mid-RUN abort the program with no drain: PC returns to START_PC after one edge.
- Simultaneous start and halt_req: start wins.
- Simultaneous stall and branch_en: stall wins and the branch is not taken. The control unit must re-present the branch once the stall drops.

## Structure

- The shared package pc_pkg holds:
  - the state enum typedef (IDLE, RUN, HALTED), 2 bits;
  - the default width constants PC_W = 12 and RET_W = 16;
  - START_PC_DEFAULT.
- One natural sub-module, pc_next_calc. It is combinational and computes the next PC from PC, target, branch_en and stall. It is kept separate so its wrap-around arithmetic can be unit-tested in isolation.
- The state register, PC register and retired counter stay in pc_fetch_ctrl.

## Test plan

- Reset, then start high for 3 cycles, then low → prog_ctr = 0 throughout IDLE. running rises one edge after start falls, then PC steps 0, 1, 2, 3 and retired steps 1, 2, 3.
- RUN at PC = 4, branch_en with target = 0xFFB (-5) → PC = 0xFFF. Next branch with target = 20 (0x014) → PC = 0x013 (wrapped). Next branch with target = 0xFFF → PC = 0x012.
- RUN at PC = 7, stall high for 2 cycles with branch_en high → PC holds at 7 and retired holds. Stall drops with branch_en, target = 0 → PC stays 7 and retired +1.
- RUN, halt_req pulse at PC = 0x010 → done = 1, running = 0, PC holds 0x010. Further branch_en/stall are ignored. start high → done = 0, PC = 0 after one edge.
- Simultaneous start and halt_req in RUN → IDLE with done = 0. Reset asserted mid-RUN at PC = 0x055 → all outputs at reset values after one edge.
- CW = 4 instance, run 20 unstalled cycles → retired saturates at 15 and holds.
